// File: rtl/mux_2to1_arbiter_pkg.sv
// rtl/mux_2to1_arbiter_pkg.sv - shared state encodings and defaults for the 2:1 arbiter
package mux_2to1_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_e;

  localparam int MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/mux_2to1_arbiter_hold_counter.sv
// rtl/mux_2to1_arbiter_hold_counter.sv - grant hold counter with wrap flag at MAX_HOLD-1
module hold_counter #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = $clog2(MAX_HOLD)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign wrap_o = (cnt_q == CNT_LAST);

  // Explicit wrap: MAX_HOLD need not be a power of two.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_2to1_arbiter_mux.sv
// rtl/mux_2to1_arbiter_mux.sv - shared 2:1 datapath mux
module mux_2to1 (
  input  logic [1:0] in_i,
  input  logic       s_i,
  output logic       out_o
);

  assign out_o = in_i[s_i];

endmodule

// File: rtl/mux_2to1_arbiter.sv
// rtl/mux_2to1_arbiter.sv - round-robin arbiter driving the select of a shared 2:1 mux
module mux_2to1_arbiter
  import mux_2to1_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CW       = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] d,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       out,
  output logic       valid
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   sel_q, sel_d;
  logic   cnt_clr, cnt_en, cnt_wrap;
  logic   take, tgt, k;

  hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .wrap_o (cnt_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  // take/tgt: hand the path to requester tgt, restarting its hold window.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    take    = 1'b0;
    tgt     = 1'b0;
    k       = (state_q == ST_G1);
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          take = 1'b1;
          tgt  = (req == 2'b11) ? ~last_q : req[1];
        end
      end
      ST_G0, ST_G1: begin
        if (!req[k]) begin
          if (req[~k]) begin
            take = 1'b1;
            tgt  = ~k;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_wrap && req[~k]) begin
          take = 1'b1;
          tgt  = ~k;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = tgt ? ST_G1 : ST_G0;
      last_d  = tgt;
      sel_d   = tgt;
      cnt_clr = 1'b1;
    end
  end

  always_comb begin
    gnt   = {state_q == ST_G1, state_q == ST_G0};
    valid = |gnt;
    sel   = sel_q;
  end

  mux_2to1 u_mux (
    .in_i  (d),
    .s_i   (sel_q),
    .out_o (out)
  );

endmodule
